// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game-loop control sequencer and its frame timer.
package game_ctrl_pkg;

    typedef enum logic [1:0] {
        CHECK      = 2'd0,
        START      = 2'd1,
        WAIT       = 2'd2,
        FRAME_WAIT = 2'd3
    } seq_state_t;

    localparam int GRANT_NONE          = 0;
    localparam int DEFAULT_FRAME_TICKS = 1700000;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame pacer: pulses tick for one cycle every FRAME_TICKS cycles.
module frame_timer
    import game_ctrl_pkg::*;
#(
    parameter int FRAME_TICKS = DEFAULT_FRAME_TICKS
)(
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= RELOAD;
        end else if (count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/task_sequencer.sv
// Game-loop sequencer: walks a chain of sub-units over start/done handshakes,
// grants the shared resources to the active unit and paces the loop to frame ticks.
module task_sequencer
    import game_ctrl_pkg::*;
#(
    parameter int NUM_TASKS   = 6,
    parameter int LOOP_START  = 1,
    parameter int FRAME_TICKS = DEFAULT_FRAME_TICKS,
    parameter int TIMEOUT     = 1048576,
    localparam int IDXW       = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_TASKS-1:0] enable_mask,
    input  logic [NUM_TASKS-1:0] done,
    input  logic                 restart,
    output logic [NUM_TASKS-1:0] start,
    output logic [NUM_TASKS-1:0] grant,
    output logic [IDXW-1:0]      cur_task,
    output logic                 frame_tick,
    output logic [15:0]          frame_count,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDXW-1:0]      LAST_IDX     = IDXW'(NUM_TASKS - 1);
    localparam logic [IDXW-1:0]      LOOP_IDX     = IDXW'(LOOP_START);
    localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [NUM_TASKS-1:0] ONE_HOT0     = NUM_TASKS'(1);
    localparam logic [NUM_TASKS-1:0] NO_GRANT     = NUM_TASKS'(GRANT_NONE);

    seq_state_t    state;
    logic [TW-1:0] wait_cnt;
    logic          done_seen;
    logic          timed_out;
    logic          is_last;

    frame_timer #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_frame_timer (
        .clock(clock),
        .reset(reset),
        .tick (frame_tick)
    );

    assign done_seen = done[cur_task];
    assign timed_out = (TIMEOUT > 0) && (wait_cnt == TIMEOUT_LAST);
    assign is_last   = (cur_task == LAST_IDX);
    assign busy      = (state != FRAME_WAIT);

    // Restart outranks every transition; a timeout advances the chain as if done had arrived.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= CHECK;
            cur_task    <= '0;
            start       <= '0;
            grant       <= NO_GRANT;
            frame_count <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else if (restart) begin
            state       <= CHECK;
            cur_task    <= '0;
            start       <= '0;
            grant       <= NO_GRANT;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            start <= '0;
            case (state)
                CHECK: begin
                    if (enable_mask[cur_task]) begin
                        state <= START;
                        start <= ONE_HOT0 << cur_task;
                    end else if (is_last) begin
                        state <= FRAME_WAIT;
                    end else begin
                        cur_task <= cur_task + 1'b1;
                    end
                end
                START: begin
                    state    <= WAIT;
                    grant    <= ONE_HOT0 << cur_task;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (done_seen || timed_out) begin
                        if (!done_seen) begin
                            timeout_err <= 1'b1;
                        end
                        grant <= NO_GRANT;
                        if (is_last) begin
                            state <= FRAME_WAIT;
                        end else begin
                            cur_task <= cur_task + 1'b1;
                            state    <= CHECK;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FRAME_WAIT: begin
                    if (frame_tick) begin
                        cur_task    <= LOOP_IDX;
                        frame_count <= frame_count + 16'd1;
                        state       <= CHECK;
                    end
                end
                default: begin
                    state <= CHECK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task_sequencer.sv
// Directed bench for task_sequencer (4 tasks, loop from task 1, 50-cycle frames, timeout 20).
module tb_task_sequencer;

    logic       clock;
    logic       reset;
    logic [3:0] enable_mask;
    logic [3:0] done;
    logic       restart;
    logic [3:0] start;
    logic [3:0] grant;
    logic [1:0] cur_task;
    logic       frame_tick;
    logic [15:0] frame_count;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int gap;
    int n_starts;
    int tick_edge;

    task_sequencer #(
        .NUM_TASKS  (4),
        .LOOP_START (1),
        .FRAME_TICKS(50),
        .TIMEOUT    (20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable_mask(enable_mask),
        .done       (done),
        .restart    (restart),
        .start      (start),
        .grant      (grant),
        .cur_task   (cur_task),
        .frame_tick (frame_tick),
        .frame_count(frame_count),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [3:0] onehot(input int i);
        onehot = 4'b0001 << i;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // gap = cycles spent waiting before the start pulse showed up
    task automatic wait_start(input int idx, output int g);
        g = 0;
        while (start === 4'b0000 && g < 100) begin
            step();
            g++;
        end
        check("start_pulse", 32'(start), 32'(onehot(idx)));
        check("start_cur", 32'(cur_task), idx);
        check("start_no_grant", 32'(grant), 0);
    endtask

    task automatic run_task(input int idx, input int lat, output int g);
        wait_start(idx, g);
        for (int c = 1; c <= lat; c++) begin
            step();
            check("wait_grant", 32'(grant), 32'(onehot(idx)));
            if (c == 1) check("start_single", 32'(start), 0);
            if (c == lat) done = onehot(idx);
        end
        step();
        done = '0;
        check("release_grant", 32'(grant), 0);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 120) begin
            step();
            n++;
        end
        check("tick_seen", 32'(frame_tick), 1);
        check("tick_idle", 32'(busy), 0);
    endtask

    initial begin
        reset       = 1'b1;
        restart     = 1'b0;
        done        = '0;
        enable_mask = 4'b1111;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_start", 32'(start), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_cur", 32'(cur_task), 0);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_fc", 32'(frame_count), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_err", 32'(timeout_err), 0);
        #6 reset = 1'b0;
        step();

        $display("[TB] full chain, init task then loop");
        run_task(0, 3, gap);
        check("gap_t0", gap, 0);
        run_task(1, 3, gap);
        check("gap_t1", gap, 1);
        run_task(2, 3, gap);
        run_task(3, 3, gap);
        check("fw_busy", 32'(busy), 0);
        check("fw_grant", 32'(grant), 0);
        wait_tick();
        step();
        check("fc_1", 32'(frame_count), 1);
        check("loop_cur", 32'(cur_task), 1);
        run_task(1, 3, gap);
        check("loop_gap", gap, 1);
        run_task(2, 3, gap);
        run_task(3, 3, gap);

        $display("[TB] masked task and empty mask");
        enable_mask = 4'b1011;
        wait_tick();
        step();
        check("fc_2", 32'(frame_count), 2);
        run_task(1, 3, gap);
        check("skip_cur", 32'(cur_task), 2);
        check("skip_start", 32'(start), 0);
        run_task(3, 2, gap);
        check("skip_gap", gap, 2);
        check("skip_fw", 32'(busy), 0);
        enable_mask = 4'b0000;
        wait_tick();
        step();
        check("fc_3", 32'(frame_count), 3);
        n_starts = 0;
        for (int c = 0; c < 3; c++) begin
            if (start !== 4'b0000) n_starts++;
            step();
        end
        check("zero_no_start", n_starts, 0);
        check("zero_fw", 32'(busy), 0);
        wait_tick();
        enable_mask = 4'b1111;
        step();
        check("fc_4", 32'(frame_count), 4);

        $display("[TB] stalled task times out");
        wait_start(1, gap);
        for (int c = 1; c <= 20; c++) begin
            step();
            check("to_grant", 32'(grant), 32'(onehot(1)));
        end
        check("to_err_pre", 32'(timeout_err), 0);
        step();
        check("to_err", 32'(timeout_err), 1);
        check("to_cur", 32'(cur_task), 2);
        check("to_grant_off", 32'(grant), 0);
        run_task(2, 3, gap);
        check("to_gap", gap, 1);
        run_task(3, 3, gap);
        wait_tick();
        check("to_sticky", 32'(timeout_err), 1);
        step();
        check("fc_5", 32'(frame_count), 5);

        $display("[TB] restart mid-wait");
        run_task(1, 3, gap);
        wait_start(2, gap);
        step();
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("rs_cur", 32'(cur_task), 0);
        check("rs_grant", 32'(grant), 0);
        check("rs_start", 32'(start), 0);
        check("rs_busy", 32'(busy), 1);
        check("rs_err", 32'(timeout_err), 0);
        check("rs_fc", 32'(frame_count), 5);
        run_task(0, 3, gap);
        check("rs_gap", gap, 1);

        $display("[TB] done coincides with last allowed wait cycle");
        wait_start(1, gap);
        for (int c = 1; c <= 20; c++) begin
            step();
            check("edge_grant", 32'(grant), 32'(onehot(1)));
            if (c == 6) check("spurious_cur", 32'(cur_task), 1);
            if (c == 5) done = 4'b1000;
            if (c == 6) done = 4'b0000;
            if (c == 20) done = 4'b0010;
        end
        step();
        done = '0;
        check("edge_err", 32'(timeout_err), 0);
        check("edge_cur", 32'(cur_task), 2);
        check("edge_grant_off", 32'(grant), 0);
        run_task(2, 3, gap);
        run_task(3, 3, gap);

        $display("[TB] asynchronous reset mid-frame");
        wait_tick();
        step();
        check("fc_6", 32'(frame_count), 6);
        step();
        step();
        check("pre_rst_grant", 32'(grant), 32'(onehot(1)));
        #2 reset = 1'b1;
        #1;
        check("arst_start", 32'(start), 0);
        check("arst_grant", 32'(grant), 0);
        check("arst_cur", 32'(cur_task), 0);
        check("arst_fc", 32'(frame_count), 0);
        check("arst_busy", 32'(busy), 1);
        check("arst_tick", 32'(frame_tick), 0);
        @(posedge clock);
        #3 reset = 1'b0;
        step();
        check("arst_first_start", 32'(start), 32'(onehot(0)));
        tick_edge = 0;
        for (int k = 1; k <= 60 && tick_edge == 0; k++) begin
            if (frame_tick === 1'b1) tick_edge = k + 1;
            else step();
        end
        check("arst_tick_edge", tick_edge, 50);
        check("arst_timeout", 32'(timeout_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/task_sequencer.md
Name: task_sequencer

Overview:
Parametrised top-level control sequencer for the game loop. It runs a configurable chain of sub-units (level loader, grid draw, player draw, raytracer, updaters, ...) over start/done handshakes. It grants exclusive shared-resource access (grid RAM, VGA port) to the active unit. It paces the repeating part of the chain to a frame tick, and adds a per-task enable mask, a restart input and a stall timeout.

Parameters:
NUM_TASKS, 6, number of sub-units sequenced; task index i maps to start[i]/done[i]/grant[i].
LOOP_START, 1, first index of the repeating loop; tasks 0..LOOP_START-1 run once after reset/restart. Legal range 0..NUM_TASKS-1.
FRAME_TICKS, 1700000, frame period in clock cycles; must be at least 2.
TIMEOUT, 1048576, maximum cycles in WAIT before the task is abandoned; 0 disables the timeout.
(localparam IDXW = max(1, $clog2(NUM_TASKS)))

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable_mask  in  NUM_TASKS  1 = task runs; 0 = task skipped; sampled in CHECK
done  in  NUM_TASKS  completion pulse/level from each sub-unit
restart  in  1  synchronous pulse; re-runs the chain from task 0
start  out  NUM_TASKS  one-hot, single-cycle start pulse
grant  out  NUM_TASKS  one-hot resource-access select; held for the whole WAIT
cur_task  out  IDXW  index of the task currently being checked, started or awaited
frame_tick  out  1  single-cycle pulse, once every FRAME_TICKS cycles
frame_count  out  16  number of completed loop iterations; wraps at 65535 -> 0
busy  out  1  0 only in FRAME_WAIT
timeout_err  out  1  sticky flag; a task exceeded TIMEOUT

Behaviour:
- States: CHECK, START, WAIT, FRAME_WAIT.
- Reset (async): state=CHECK, cur_task=0, start=0, grant=0, frame timer=FRAME_TICKS-1, frame_tick=0, frame_count=0, timeout_err=0, busy=1. All outputs are registered or decoded from registered state.
- CHECK:
  - If enable_mask[cur_task]=1, go to START.
  - Otherwise, if cur_task is the last index, go to FRAME_WAIT; else cur_task+1 and stay in CHECK.
  - Each disabled task costs exactly 1 cycle.
- START: start[cur_task]=1 for exactly this cycle; grant=0. Next state is WAIT, with the timeout counter cleared.
- WAIT:
  - grant[cur_task]=1 and all other grant bits are 0.
  - On done[cur_task]=1: if last index, go to FRAME_WAIT; else cur_task+1 and go to CHECK.
  - done bits for other indices are ignored, as is any done outside WAIT. A done asserted in the same cycle as start is not seen.
  - Minimum task latency: start pulse at cycle N, done sampled at N+1 or later.
- Timeout (TIMEOUT>0): the counter increments each WAIT cycle. When it reaches TIMEOUT with no done, set timeout_err and advance exactly as if done had arrived. If done and timeout occur in the same cycle, done wins and timeout_err is not set.
- FRAME_WAIT: grant=0, busy=0. On frame_tick: cur_task=LOOP_START, frame_count+1, go to CHECK. A tick in the same cycle the FSM enters FRAME_WAIT is missed; the FSM waits for the next tick (no catch-up). Missed ticks while busy are dropped.
- Frame timer: free-running down-counter, reloads FRAME_TICKS-1 at 0. frame_tick=1 in the cycle the counter is 0. It is unaffected by restart.
- restart (priority over all transitions except reset):
  - Next cycle: state=CHECK, cur_task=0, timeout_err=0, start/grant=0.
  - The in-flight task is abandoned; sub-units must tolerate this.
  - frame_count is not cleared.
- All-zero enable_mask: CHECK walks the indices, then FRAME_WAIT; the loop spins at frame rate without starting anything. frame_count still increments.
- LOOP_START=0: every task reruns each frame, with no init-only tasks.

Decomposition:
- Shared package game_ctrl_pkg: state encoding (2-bit enum CHECK/START/WAIT/FRAME_WAIT), GRANT_NONE constant, default FRAME_TICKS value.
- One sub-module, frame_timer (parameter FRAME_TICKS; ports clock, reset, tick). It is reusable by the VGA write-window logic.

Test Plan:
Bench parameters: NUM_TASKS=4, LOOP_START=1, FRAME_TICKS=50, TIMEOUT=20.
1. Mask 4'b1111; each done returns 3 cycles after start -> start pulses 0,1,2,3 in order. grant matches cur_task only during WAIT. Then FRAME_WAIT, busy=0. On tick: restart at task 1 (task 0 never again), frame_count=1.
2. Mask 4'b1011 -> task 2 is never started and costs 1 CHECK cycle. Order per frame is 1,3. With all-zero mask: no start pulses and frame_count still increments per tick.
3. Task 1 never raises done -> after 20 WAIT cycles timeout_err=1 and start[2] is pulsed 2 cycles later (CHECK, START). timeout_err stays 1 until restart.
4. done[1] and the 20th WAIT cycle coincide -> timeout_err stays 0. A spurious done[3] during task 1's WAIT is ignored.
5. restart pulsed mid-WAIT of task 2 -> next cycle state=CHECK, cur_task=0, grant=0. start[0] follows one cycle later. frame_count is unchanged.
6. Async reset asserted mid-frame (not clock-aligned) -> all outputs go to reset values immediately. After release: start[0] at 2nd rising edge, first frame_tick 50 cycles after release.
